// File: rtl/noc_params.sv
// Shared NoC parameters and flit payload types used by the router input ports.
package noc_params;

  localparam int unsigned VC_SIZE           = 2;
  localparam int unsigned DEST_ADDR_SIZE_X  = 2;
  localparam int unsigned DEST_ADDR_SIZE_Y  = 2;
  localparam int unsigned HEAD_PAYLOAD_SIZE = 16;
  localparam int unsigned FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  // Head flits carry routing info; body/tail flits reuse the same bits as raw payload.
  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;

  localparam int unsigned FLIT_W = $bits(flit_t);

endpackage

// File: rtl/circular_buffer.sv
// Per-VC first-word-fall-through flit FIFO built as a ring of registers.
module circular_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  read_i,
  input  logic  write_i,
  output flit_t data_o,
  output logic  is_full_o,
  output logic  is_empty_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;

  flit_t              r_memory [BUFFER_SIZE];
  logic [PTR_W-1:0]   r_read_ptr;
  logic [PTR_W-1:0]   r_write_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_do_write;
  logic               w_do_read;
  logic [CNT_W-1:0]   w_count_nxt;

  // A full buffer still accepts a write when the head is popped the same cycle.
  assign w_do_write = write_i & (~is_full_o | read_i);
  assign w_do_read  = read_i & ~is_empty_o;

  assign is_empty_o = (r_count == '0);
  assign is_full_o  = (r_count == CNT_W'(BUFFER_SIZE));
  assign data_o     = r_memory[r_read_ptr];

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_write && !w_do_read) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_write && w_do_read) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointer and occupancy state; pointers wrap naturally on power-of-two sizes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_ptr  <= '0;
      r_write_ptr <= '0;
      r_count     <= '0;
    end else begin
      if (w_do_write) begin
        r_write_ptr <= r_write_ptr + PTR_W'(1);
      end
      if (w_do_read) begin
        r_read_ptr <= r_read_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Storage array is never reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_memory[r_write_ptr] <= data_i;
    end
  end

endmodule

// File: tb/tb_circular_buffer.sv
// Self-checking bench for circular_buffer against a queue-based FIFO model.
module tb_circular_buffer;
  import noc_params::*;

  localparam int unsigned DEPTH = 8;

  logic  clk;
  logic  rst;
  flit_t data_i;
  logic  read_i;
  logic  write_i;
  flit_t data_o;
  logic  is_full_o;
  logic  is_empty_o;

  int n_tests;
  int n_fail;

  flit_t model_q[$];

  circular_buffer #(.BUFFER_SIZE(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .read_i     (read_i),
    .write_i    (write_i),
    .data_o     (data_o),
    .is_full_o  (is_full_o),
    .is_empty_o (is_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_t make_head(input int unsigned i);
    flit_t f;
    f                        = '0;
    f.flit_label             = HEAD;
    f.vc_id                  = VC_SIZE'(i);
    f.data.head_data.x_dest  = DEST_ADDR_SIZE_X'(i);
    f.data.head_data.y_dest  = DEST_ADDR_SIZE_Y'(i);
    f.data.head_data.head_pl = HEAD_PAYLOAD_SIZE'(i * 32'h0101);
    return f;
  endfunction

  // Compare flags and head against the model; head only matters when non-empty.
  task automatic check_outputs(input string tag);
    check({tag, ".empty"}, 32'(is_empty_o), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(is_full_o),  32'(model_q.size() == DEPTH));
    if (model_q.size() != 0) begin
      check({tag, ".data"}, 32'(data_o), 32'(model_q[0]));
    end
  endtask

  // One clock cycle of stimulus, model update at the edge, check just after.
  task automatic step(input string tag, input logic rd, input logic wr, input flit_t din);
    bit can_pop;
    bit can_push;
    read_i  = rd;
    write_i = wr;
    data_i  = din;
    @(posedge clk);
    can_pop  = rd && (model_q.size() > 0);
    can_push = wr && ((model_q.size() < DEPTH) || rd);
    if (can_pop)  void'(model_q.pop_front());
    if (can_push) model_q.push_back(din);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_q = {};
    #1;
    check({tag, ".rst_empty"}, 32'(is_empty_o), 32'd1);
    check({tag, ".rst_full"},  32'(is_full_o),  32'd0);
    read_i  = 1'b0;
    write_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs({tag, ".post_rst"});
  endtask

  initial begin
    flit_t f;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    read_i  = 1'b0;
    write_i = 1'b0;
    data_i  = '0;

    // Reset held for 5 cycles.
    #1;
    check("reset_async.empty", 32'(is_empty_o), 32'd1);
    check("reset_async.full",  32'(is_full_o),  32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset_release");

    // Fill with 8 distinct head flits.
    for (int i = 0; i < int'(DEPTH); i++) begin
      step($sformatf("fill%0d", i), 1'b0, 1'b1, make_head(i));
    end

    // Write while full with no read is dropped.
    f = make_head(15);
    f.flit_label = TAIL;
    step("full_drop", 1'b0, 1'b1, f);

    // Simultaneous read and write while full.
    step("full_rw", 1'b1, 1'b1, make_head(8));

    // Drain: flits 1..7 then 8.
    for (int i = 0; i < int'(DEPTH); i++) begin
      step($sformatf("drain%0d", i), 1'b1, 1'b0, '0);
    end

    // Reads while empty are ignored.
    step("empty_rd0", 1'b1, 1'b0, '0);
    step("empty_rd1", 1'b1, 1'b0, '0);

    // Read and write together while empty acts as a write only.
    step("empty_rw", 1'b1, 1'b1, make_head(5));
    step("pop_one", 1'b1, 1'b0, '0);

    // Partial fill then reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("refill%0d", i), 1'b0, 1'b1, make_head(i + 20));
    end
    async_reset("midfill");

    // Randomised traffic alternating between fill-biased and drain-biased phases.
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 60; c++) begin
        logic rd;
        logic wr;
        if (blk[0] == 1'b0) begin
          wr = ($urandom % 4) != 0;
          rd = ($urandom % 4) == 0;
        end else begin
          wr = ($urandom % 4) == 0;
          rd = ($urandom % 4) != 0;
        end
        f = flit_t'(FLIT_W'($urandom));
        step($sformatf("rand%0d_%0d", blk, c), rd, wr, f);
      end
      if (blk == 4) begin
        async_reset("rand_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
